riscv_mem_arbiter: RTL
======================

// Module: riscv_mem_arbiter
// PURPOSE
//   Shares the single 32-bit data memory port between the core's instruction-fetch
//   requester (I) and load/store requester (D). One transaction is in flight at a time.
//   Valid/ready request handshake; one-cycle response pulse per requester.
//   Sits between riscv_core and the memory model; fixed-latency memory.
// PARAMETERS
//   MEM_LATENCY   1   cycles from mem_en to mem_rdata valid (legal range >= 1)
//   STARVE_LIMIT  4   consecutive D grants with I waiting before I is forced (>= 1)
// PORTS
//   clk           in   1   clock, all state updates on posedge
//   rst_b         in   1   synchronous active-low reset
//   halted        in   1   core halted; blocks new grants
//   i_req_valid   in   1   fetch request
//   i_req_ready   out  1   fetch request accepted this cycle
//   i_req_addr    in   32  fetch byte address; bits [1:0] ignored
//   i_resp_valid  out  1   fetch data valid pulse
//   i_resp_data   out  32  fetched word
//   d_req_valid   in   1   load/store request
//   d_req_ready   out  1   load/store request accepted this cycle
//   d_req_addr    in   32  byte address; bits [1:0] ignored
//   d_req_we      in   1   1 = store, 0 = load
//   d_req_wdata   in   32  store data
//   d_req_be      in   4   byte enables, bit n = byte lane n
//   d_resp_valid  out  1   load data / store ack pulse
//   d_resp_data   out  32  loaded word (0 for stores)
//   mem_en        out  1   memory access strobe
//   mem_write_en  out  1   memory write strobe
//   mem_addr      out  32  {addr[31:2],2'b00}
//   mem_be        out  4   byte enables to memory
//   mem_wdata     out  32  write data to memory
//   mem_rdata     in   32  read data, valid MEM_LATENCY cycles after mem_en
//   busy          out  1   1 whenever state != IDLE
// BEHAVIOUR
//   - Reset (rst_b=0 at posedge): state IDLE, streak counter 0, every output 0.
//     In-flight transaction is dropped; no response is ever issued for it.
//   - FSM: IDLE -> ACCESS -> WAIT (MEM_LATENCY cycles) -> RESP -> IDLE.
//   - IDLE: if !halted and any valid, exactly one ready is driven high combinationally.
//     Handshake = valid && ready. Request fields are registered; next state is ACCESS.
//     Ready is 0 in all other states.
//   - Arbitration: D wins when both are valid, unless streak == STARVE_LIMIT, then I wins.
//     Streak +1 on a D grant while i_req_valid=1. Streak clears on an I grant, or on
//     a D grant with i_req_valid=0.
//   - ACCESS (1 cycle): mem_en=1; mem_addr/mem_be/mem_wdata driven from the registered
//     request. mem_write_en = we && (be != 0). Fetch uses be=4'hF, we=0.
//   - WAIT: mem_addr/be/wdata are held and mem_en=0. The down-counter is loaded with
//     MEM_LATENCY in ACCESS. mem_rdata is captured on the edge leaving the last WAIT cycle.
//   - RESP (1 cycle): owner's resp_valid=1 and resp_data=captured word (0 for stores).
//     The other resp_valid stays 0. resp_data holds its value until the next RESP.
//   - Timing: handshake in cycle T -> mem_en in T+1 -> resp_valid in T+2+MEM_LATENCY.
//     Throughput is one transaction per MEM_LATENCY+3 cycles.
//   - Store with be=0: no memory write; d_resp_valid still pulses at normal latency.
//   - halted rising mid-transaction: the transaction completes normally. No new grant
//     while halted=1; valid may stay high without being accepted.
//   - Requester holds its valid and fields until ready; the arbiter does not require
//     valid to remain asserted after the handshake.
// TESTING
//   1. Fetch 0x0000_0104 with mem word 0xDEAD_BEEF, MEM_LATENCY=1 -> mem_addr=0x104,
//      mem_be=F in T+1; i_resp_valid=1 with data 0xDEADBEEF in T+3.
//   2. Store addr 0x23, wdata 0x1122_3344, be=4'b0100 -> mem_addr=0x20,
//      mem_write_en=1 for 1 cycle, d_resp_valid at T+3 with data 0.
//   3. I and D both held valid continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
//   4. rst_b=0 during WAIT -> next cycle all outputs 0 and busy=0; no resp_valid ever for
//      the aborted request; a new fetch after reset completes normally.
//   5. halted=1 raised the cycle after a D handshake -> D response still arrives at T+3.
//      i_req_valid=1 is never accepted.
//   6. MEM_LATENCY=3 load, store with be=0 -> load resp at T+5; store: mem_write_en
//      stays 0, d_resp_valid pulses at T+5.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - single-port data memory arbiter between fetch (I) and load/store (D)
//
// Purpose: grants the shared memory port to one requester at a time and runs one
// transaction through IDLE -> ACCESS -> WAIT (MEM_LATENCY cycles) -> RESP.
// D is preferred, but after STARVE_LIMIT back-to-back D grants with I waiting, I is forced.
//
// Ports:
//   clk, rst_b                 clock, synchronous active-low reset
//   halted                     blocks new grants (an in-flight transaction still completes)
//   i_req_*/i_resp_*           fetch request (valid/ready/addr) and response pulse/data
//   d_req_*/d_resp_*           load/store request (valid/ready/addr/we/wdata/be) and response
//   mem_*                      memory strobe, write strobe, word address, byte enables, data
//   busy                       high whenever a transaction is in flight
module riscv_mem_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        halted,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_resp_valid,
  output logic [31:0] i_resp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_be,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic        mem_en,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam int CNT_W  = $clog2(MEM_LATENCY + 1);
  localparam int STRK_W = $clog2(STARVE_LIMIT + 1);

  logic [1:0]        state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [STRK_W-1:0] streak_q, streak_d;
  logic              own_d_q,  own_d_d;   // 1 = D owns the current transaction
  logic [29:0]       addr_q,   addr_d;
  logic              we_q,     we_d;
  logic [3:0]        be_q,     be_d;
  logic [31:0]       wdata_q,  wdata_d;
  logic [31:0]       i_data_q, i_data_d;
  logic [31:0]       d_data_q, d_data_d;

  logic can_grant;
  logic grant_i;
  logic grant_d;
  logic hold;

  // Byte offset bits are dropped; memory is word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_req_addr[1:0], d_req_addr[1:0]};

  assign can_grant = (state_q == ST_IDLE) && !halted && rst_b;
  assign grant_i   = can_grant && i_req_valid &&
                     (!d_req_valid || (streak_q == STRK_W'(STARVE_LIMIT)));
  assign grant_d   = can_grant && d_req_valid && !grant_i;

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;
    own_d_d  = own_d_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    i_data_d = i_data_q;
    d_data_d = d_data_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_i) begin
          own_d_d  = 1'b0;
          addr_d   = i_req_addr[31:2];
          we_d     = 1'b0;
          be_d     = 4'hF;
          wdata_d  = 32'h0;
          streak_d = '0;
          state_d  = ST_ACCESS;
        end else if (grant_d) begin
          own_d_d  = 1'b1;
          addr_d   = d_req_addr[31:2];
          we_d     = d_req_we;
          be_d     = d_req_be;
          wdata_d  = d_req_wdata;
          // Only count D wins that actually made I wait.
          streak_d = i_req_valid ? streak_q + 1'b1 : '0;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_d   = CNT_W'(MEM_LATENCY);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          // Read data is valid in this last WAIT cycle; land it straight in the owner's register.
          if (own_d_q) d_data_d = we_q ? 32'h0 : mem_rdata;
          else         i_data_d = mem_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      streak_q <= '0;
      own_d_q  <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      i_data_q <= '0;
      d_data_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
      own_d_q  <= own_d_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      i_data_q <= i_data_d;
      d_data_q <= d_data_d;
    end
  end

  // Address/be/data are presented in ACCESS and held through WAIT, zero otherwise.
  assign hold         = (state_q == ST_ACCESS) || (state_q == ST_WAIT);
  assign busy         = (state_q != ST_IDLE);
  assign mem_en       = (state_q == ST_ACCESS);
  assign mem_write_en = (state_q == ST_ACCESS) && we_q && (be_q != 4'h0);
  assign mem_addr     = hold ? {addr_q, 2'b00} : 32'h0;
  assign mem_be       = hold ? be_q : 4'h0;
  assign mem_wdata    = hold ? wdata_q : 32'h0;
  assign i_resp_valid = (state_q == ST_RESP) && !own_d_q;
  assign d_resp_valid = (state_q == ST_RESP) && own_d_q;
  assign i_resp_data  = i_data_q;
  assign d_resp_data  = d_data_q;

endmodule
